// File: rtl/serializer_piso_32bit.sv
// Parallel-in serial-out shifter: MSB first, one bit per enabled cycle,
// back-to-back frames when a new word is offered on the last bit.
module serializer_piso_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               load;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state and handshake/serial outputs
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    done_d       = 1'b0;
    busy         = (state_q == SHIFT);
    serial_valid = busy && shift_en;
    first_bit    = serial_valid && (count_q == '0);
    last_bit     = serial_valid && (count_q == CNT_LAST);
    load_ready   = !busy || last_bit;
    serial_out   = busy && shreg_q[WIDTH-1];
    load         = load_valid && load_ready;

    done_d = last_bit;
    if (load) begin
      // A load on the last bit chains the next frame without a gap cycle
      state_d = SHIFT;
      shreg_d = load_data;
      count_d = '0;
    end else if (last_bit) begin
      state_d = IDLE;
      count_d = '0;
    end else if (serial_valid) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      count_d = count_q + CNT_W'(1);
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_serializer_piso_32bit.sv
// Scoreboard bench for serializer_piso_32bit: expected bits queued on each
// accepted load, popped on each valid serial bit and reassembled by a SIPO.
module tb_serializer_piso_32bit;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  load_data;
  logic          load_valid;
  logic          load_ready;
  logic          shift_en;
  logic          serial_out;
  logic          serial_valid;
  logic          first_bit;
  logic          last_bit;
  logic          busy;
  logic          done;

  serializer_piso_32bit #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .first_bit    (first_bit),
    .last_bit     (last_bit),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state and scoreboard
  logic          exp_q[$];
  logic [W-1:0]  word_q[$];
  logic [W-1:0]  sipo = '0;
  logic          m_busy = 1'b0;
  int            m_cnt = 0;
  logic          m_done = 1'b0;
  logic          e_ready, e_valid, e_first, e_last, bit_exp;

  int            valid_cnt = 0;
  int            done_cnt = 0;
  int            last_done_cyc = 0;
  int            done_gap = 0;
  int            busy_low = 0;
  logic          watch = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    e_ready = !m_busy || (m_cnt == W - 1 && shift_en);
    e_valid = m_busy && shift_en;
    e_first = e_valid && (m_cnt == 0);
    e_last  = e_valid && (m_cnt == W - 1);

    check("busy",  32'(busy),         32'(m_busy));
    check("ready", 32'(load_ready),   32'(e_ready));
    check("valid", 32'(serial_valid), 32'(e_valid));
    check("first", 32'(first_bit),    32'(e_first));
    check("last",  32'(last_bit),     32'(e_last));
    check("done",  32'(done),         32'(m_done));

    if (!m_busy) begin
      check("idle_out", 32'(serial_out), 32'd0);
    end else if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else if (e_valid) begin
      bit_exp = exp_q.pop_front();
      check("bit", 32'(serial_out), 32'(bit_exp));
      sipo = {sipo[W-2:0], serial_out};
      valid_cnt++;
      if (e_last) check("sipo_word", sipo, word_q.pop_front());
    end else begin
      check("stall_out", 32'(serial_out), 32'(exp_q[0]));
    end

    if (done) begin
      if (done_cnt > 0) done_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
      done_cnt++;
    end
    if (watch && !busy) busy_low++;

    // advance the model across the coming edge
    if (reset) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_done = 1'b0;
      exp_q.delete();
      word_q.delete();
    end else begin
      m_done = e_last;
      if (load_valid && e_ready) begin
        for (int b = W - 1; b >= 0; b--) exp_q.push_back(load_data[b]);
        word_q.push_back(load_data);
        m_busy = 1'b1;
        m_cnt  = 0;
      end else if (e_last) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else if (e_valid) begin
        m_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    done_cnt  = 0;
    done_gap  = 0;
    busy_low  = 0;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; shift_en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // single frame with a marker bit at each end
    clear_counts();
    shift_en = 1'b1; load_valid = 1'b1; load_data = 32'h8000_0001;
    tick(1);
    load_valid = 1'b0;
    tick(34);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd32);
    check("t1_done_cnt",  32'(done_cnt),  32'd1);

    // alternating stalls
    clear_counts();
    load_valid = 1'b1; load_data = 32'hA5A5_5A5A;
    tick(1);
    load_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      shift_en = (i % 2 == 0);
      tick(1);
    end
    shift_en = 1'b1;
    tick(2);
    check("t2_valid_cnt", 32'(valid_cnt), 32'd32);
    check("t2_done_cnt",  32'(done_cnt),  32'd1);

    // back-to-back frames with load_valid held
    clear_counts();
    load_valid = 1'b1; load_data = 32'h1234_5678;
    tick(1);
    watch = 1'b1;
    load_data = 32'hDEAD_BEEF;
    tick(32);
    load_valid = 1'b0;
    tick(32);
    watch = 1'b0;
    tick(2);
    check("t3_valid_cnt", 32'(valid_cnt), 32'd64);
    check("t3_busy_low",  32'(busy_low),  32'd0);
    check("t3_done_cnt",  32'(done_cnt),  32'd2);
    check("t3_done_gap",  32'(done_gap),  32'd32);

    // offer mid-frame must be ignored
    clear_counts();
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF;
    tick(1);
    load_valid = 1'b0;
    tick(10);
    load_valid = 1'b1; load_data = 32'h0;
    tick(3);
    load_valid = 1'b0;
    tick(22);
    check("t4_valid_cnt", 32'(valid_cnt), 32'd32);
    check("t4_done_cnt",  32'(done_cnt),  32'd1);

    // reset aborts a frame at count 15
    clear_counts();
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF;
    tick(1);
    load_valid = 1'b0;
    tick(15);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_busy",  32'(busy),       32'd0);
    check("t5_out",   32'(serial_out), 32'd0);
    check("t5_ready", 32'(load_ready), 32'd1);
    tick(4);
    check("t5_done_cnt", 32'(done_cnt), 32'd0);

    // reset wins over a simultaneous load
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF; reset = 1'b1;
    tick(1);
    reset = 1'b0; load_valid = 1'b0;
    check("t6_busy", 32'(busy),       32'd0);
    check("t6_out",  32'(serial_out), 32'd0);
    tick(3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = $urandom;
      shift_en   = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    load_valid = 1'b0; shift_en = 1'b1;
    tick(40);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serializer_piso_32bit.md
SERIALIZER_PISO_32BIT -- requirements
Module: serializer_piso_32bit

Interface
REQ-001 Parameter: WIDTH, 32, word length in bits; legal values are WIDTH >= 2.
REQ-002 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-004 Port: load_data  in  WIDTH  parallel word to transmit.
REQ-005 Port: load_valid  in  1  load_data is offered for transmission.
REQ-006 Port: load_ready  out  1  block accepts a word this cycle.
REQ-007 Port: shift_en  in  1  advance enable; 0 stalls the shifter.
REQ-008 Port: serial_out  out  1  current serial bit, MSB first.
REQ-009 Port: serial_valid  out  1  serial_out is transferred this cycle.
REQ-010 Port: first_bit  out  1  the bit transferred this cycle is bit WIDTH-1 of the word.
REQ-011 Port: last_bit  out  1  the bit transferred this cycle is bit 0 of the word.
REQ-012 Port: busy  out  1  a word is in flight (state SHIFT).
REQ-013 Port: done  out  1  one-cycle pulse on the cycle after a word's last bit.

Function
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 A load SHALL occur when load_valid=1 and load_ready=1 on a clock edge. On a load: shreg <= load_data, count <= 0, state <= SHIFT.
REQ-016 load_ready SHALL be 1 in IDLE, and in SHIFT when count=WIDTH-1 and shift_en=1; it SHALL be 0 otherwise.
REQ-017 In SHIFT, serial_out SHALL equal shreg[WIDTH-1] combinationally. In IDLE, serial_out SHALL be 0.
REQ-018 serial_valid SHALL be (state=SHIFT) and shift_en.
REQ-019 first_bit SHALL be serial_valid and count=0.
REQ-020 last_bit SHALL be serial_valid and count=WIDTH-1.
REQ-021 On each edge with serial_valid=1 and count<WIDTH-1: shreg <= shreg shifted left by one (zero-fill LSB), and count <= count+1.
REQ-022 On an edge with last_bit=1 and no load: state <= IDLE and count <= 0.
REQ-023 On an edge with last_bit=1 and a load: the new word SHALL be captured per REQ-015, and the state SHALL remain SHIFT, giving back-to-back frames with no gap cycle.
REQ-024 In SHIFT with shift_en=0: shreg, count and state SHALL hold, and serial_out SHALL remain stable.
REQ-025 While in SHIFT with count<WIDTH-1, load_valid SHALL be ignored: no capture and no corruption of the word in flight.
REQ-026 done SHALL be registered and SHALL be 1 exactly on the cycle after each last_bit=1 cycle; otherwise 0.
REQ-027 busy SHALL be (state=SHIFT).
REQ-028 Latency: a load at edge N with shift_en held at 1 SHALL give first_bit in cycle N+1 and last_bit in cycle N+WIDTH, with done at N+WIDTH+1.
REQ-029 The count register SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-030 Bit order SHALL match a SIPO receiver that shifts new bits into bit 0 toward bit WIDTH-1. After WIDTH valid bits, that receiver SHALL hold load_data unchanged.

Reset
REQ-031 With reset=1 at an edge: state <= IDLE, shreg <= 0, count <= 0, done <= 0. Consequently load_ready=1 and serial_out, serial_valid, first_bit, last_bit and busy are all 0.
REQ-032 Reset SHALL take priority over load and shift in the same cycle. Reset mid-frame SHALL abort the frame with no done pulse.

Verification
REQ-033 Reset, then load 0x8000_0001 with shift_en=1 -> serial_out sequence 1, then 30 zeros, then 1; first_bit on bit 1 of the frame; last_bit on bit 32; done pulses on the following cycle.
REQ-034 Load 0xA5A5_5A5A and toggle shift_en 1,0 alternately -> exactly 32 serial_valid cycles; serial_out stable across stalls; a reference SIPO model captures 0xA5A5_5A5A.
REQ-035 Hold load_valid=1 with 0x1234_5678 followed by 0xDEAD_BEEF -> the second word is accepted on the last_bit cycle of the first; 64 consecutive valid bits; busy never drops; done pulses twice, 32 cycles apart.
REQ-036 Load 0xFFFF_FFFF, then present load_valid=1 with 0x0 at count=10 -> the offer is ignored (load_ready=0), and all 32 transmitted bits are 1.
REQ-037 Load 0xFFFF_FFFF and assert reset at count=15 -> the next cycle shows IDLE, serial_out=0, load_ready=1, and no done pulse.
REQ-038 load_valid and reset asserted in the same cycle -> no load occurs; IDLE with shreg=0 on the next cycle.
